// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Consumer side of the hazard-detection interface for a 5-stage
//               MIPS pipeline. Turns hazard requests, branch/jump redirects
//               and an external memory wait into PC/IF-ID/ID-EX controls.
//               Sequences multi-cycle stalls and redirect squashes, and keeps
//               saturating bubble/redirect counters.
//
//               Ports:
//                 Clk, Reset        clock (rising edge), sync active-high reset
//                 HazardReq         instruction in ID must not advance
//                 HazardLoadUse     1 = load-use hazard, 0 = RAW on RegWrite
//                 BranchTaken       taken branch resolved this cycle
//                 JumpTaken         jump resolved this cycle
//                 ExtStall          memory not ready, freeze front end
//                 PCWrite           PC may update
//                 IF_ID_Write       IF/ID may load
//                 IF_ID_Flush       IF/ID loads a NOP
//                 ID_EX_Bubble      ID/EX control fields zeroed
//                 CtrlState         0 RUN, 1 STALL, 2 FLUSH (registered)
//                 StallCount        bubble cycles since reset (saturating)
//                 FlushCount        redirect events since reset (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int STALL_CYCLES    = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int CNT_W           = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             HazardReq,
    input  logic             HazardLoadUse,
    input  logic             BranchTaken,
    input  logic             JumpTaken,
    input  logic             ExtStall,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic [1:0]       CtrlState,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    // Down-counter only has to hold the largest reload value.
    localparam int c_maxA = (STALL_CYCLES > LOAD_USE_CYCLES) ? STALL_CYCLES : LOAD_USE_CYCLES;
    localparam int c_maxN = (c_maxA > FLUSH_CYCLES) ? c_maxA : FLUSH_CYCLES;
    localparam int CW     = (c_maxN < 2) ? 1 : $clog2(c_maxN + 1);

    localparam logic [CW-1:0]    c_downOne    = CW'(1);
    localparam logic [CW-1:0]    c_stallLoad  = CW'(STALL_CYCLES - 1);
    localparam logic [CW-1:0]    c_loadLoad   = CW'(LOAD_USE_CYCLES - 1);
    localparam logic [CW-1:0]    c_flushLoad  = CW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cntInc     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cntMax     = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [CW-1:0]    r_downCnt;
    logic [CNT_W-1:0] r_stallCount;
    logic [CNT_W-1:0] r_flushCount;

    logic [1:0]       w_stateNxt;
    logic [CW-1:0]    w_downCntNxt;
    logic             w_incStall;
    logic             w_incFlush;
    logic             w_redirect;

    assign w_redirect = BranchTaken | JumpTaken;

    // ------------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_stateNxt   = r_state;
        w_downCntNxt = r_downCnt;
        w_incStall   = 1'b0;
        w_incFlush   = 1'b0;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;

        if (Reset) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            w_stateNxt   = S_RUN;
            w_downCntNxt = '0;
        end else if (ExtStall) begin
            // Full freeze: nothing moves, nothing counts.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b0;
            ID_EX_Bubble = 1'b0;
        end else if (w_redirect) begin
            // Same action from every state: squash, count, (re)start flush.
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            w_incFlush   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_stateNxt   = S_FLUSH;
                w_downCntNxt = c_flushLoad;
            end else begin
                w_stateNxt   = S_RUN;
                w_downCntNxt = '0;
            end
        end else begin
            case (r_state)
                S_STALL: begin
                    // Hazard inputs are not re-sampled while draining.
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    w_incStall   = 1'b1;
                    if (r_downCnt <= c_downOne) begin
                        w_stateNxt   = S_RUN;
                        w_downCntNxt = '0;
                    end else begin
                        w_downCntNxt = r_downCnt - c_downOne;
                    end
                end
                S_FLUSH: begin
                    IF_ID_Flush  = 1'b1;
                    ID_EX_Bubble = 1'b1;
                    if (r_downCnt <= c_downOne) begin
                        w_stateNxt   = S_RUN;
                        w_downCntNxt = '0;
                    end else begin
                        w_downCntNxt = r_downCnt - c_downOne;
                    end
                end
                default: begin
                    // RUN, and any illegal encoding which recovers to RUN.
                    w_stateNxt   = S_RUN;
                    w_downCntNxt = '0;
                    if (HazardReq) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        w_incStall   = 1'b1;
                        if (HazardLoadUse) begin
                            if (LOAD_USE_CYCLES > 1) begin
                                w_stateNxt   = S_STALL;
                                w_downCntNxt = c_loadLoad;
                            end
                        end else begin
                            if (STALL_CYCLES > 1) begin
                                w_stateNxt   = S_STALL;
                                w_downCntNxt = c_stallLoad;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State, down-counter and saturating performance counters
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_RUN;
            r_downCnt    <= '0;
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            r_state   <= w_stateNxt;
            r_downCnt <= w_downCntNxt;
            if (w_incStall && (r_stallCount != c_cntMax)) begin
                r_stallCount <= r_stallCount + c_cntInc;
            end
            if (w_incFlush && (r_flushCount != c_cntMax)) begin
                r_flushCount <= r_flushCount + c_cntInc;
            end
        end
    end

    assign CtrlState  = r_state;
    assign StallCount = r_stallCount;
    assign FlushCount = r_flushCount;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Directed self-checking bench for pipeline_stall_ctrl. A
//               default instance (CNT_W=32) and a narrow instance (CNT_W=4)
//               share all inputs; the narrow one exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, HazardReq, HazardLoadUse, BranchTaken, JumpTaken, ExtStall;
    logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
    logic [1:0]  CtrlState;
    logic [31:0] StallCount, FlushCount;

    logic        sPCWrite, sIfIdWrite, sIfIdFlush, sIdExBubble;
    logic [1:0]  sCtrlState;
    logic [3:0]  sStallCount, sFlushCount;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pipeline_stall_ctrl #(.STALL_CYCLES(2), .LOAD_USE_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .HazardReq(HazardReq), .HazardLoadUse(HazardLoadUse),
        .BranchTaken(BranchTaken), .JumpTaken(JumpTaken), .ExtStall(ExtStall),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .CtrlState(CtrlState),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    pipeline_stall_ctrl #(.STALL_CYCLES(2), .LOAD_USE_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(4)) dutSat (
        .Clk(Clk), .Reset(Reset), .HazardReq(HazardReq), .HazardLoadUse(HazardLoadUse),
        .BranchTaken(BranchTaken), .JumpTaken(JumpTaken), .ExtStall(ExtStall),
        .PCWrite(sPCWrite), .IF_ID_Write(sIfIdWrite), .IF_ID_Flush(sIfIdFlush),
        .ID_EX_Bubble(sIdExBubble), .CtrlState(sCtrlState),
        .StallCount(sStallCount), .FlushCount(sFlushCount)
    );

    // Packed view of the four control outputs: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}
    wire [3:0] ctl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble};

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearInputs();
        HazardReq = 0; HazardLoadUse = 0; BranchTaken = 0; JumpTaken = 0; ExtStall = 0;
    endtask

    task automatic doReset();
        clearInputs();
        Reset = 1;
        step();
        step();
        Reset = 0;
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        Reset = 1;
        step();
        #1;
        checks++;
        if (ctl !== 4'b0011) begin
            errors++; $display("FAIL reset_outputs: ctl=%b expected=%b", ctl, 4'b0011);
        end
        step();
        Reset = 0;
        #1;
        checks++;
        if (ctl !== 4'b1100 || CtrlState !== 2'd0) begin
            errors++; $display("FAIL reset_release: ctl=%b state=%0d expected ctl=1100 state=0", ctl, CtrlState);
        end
        checks++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
            errors++; $display("FAIL reset_counts: stall=%0d flush=%0d expected 0/0", StallCount, FlushCount);
        end
    endtask

    task automatic test_raw_stall();
        doReset();
        HazardReq = 1; HazardLoadUse = 0;
        #1;
        checks++;
        if (ctl !== 4'b0001 || CtrlState !== 2'd0) begin
            errors++; $display("FAIL raw_bubble1: ctl=%b state=%0d expected ctl=0001 state=0", ctl, CtrlState);
        end
        step();
        HazardReq = 0;
        #1;
        checks++;
        if (ctl !== 4'b0001 || CtrlState !== 2'd1 || StallCount !== 32'd1) begin
            errors++; $display("FAIL raw_bubble2: ctl=%b state=%0d stall=%0d expected ctl=0001 state=1 stall=1",
                               ctl, CtrlState, StallCount);
        end
        step();
        checks++;
        if (ctl !== 4'b1100 || CtrlState !== 2'd0 || StallCount !== 32'd2) begin
            errors++; $display("FAIL raw_done: ctl=%b state=%0d stall=%0d expected ctl=1100 state=0 stall=2",
                               ctl, CtrlState, StallCount);
        end
    endtask

    task automatic test_load_use();
        doReset();
        HazardReq = 1; HazardLoadUse = 1;
        #1;
        checks++;
        if (ctl !== 4'b0001) begin
            errors++; $display("FAIL loaduse_bubble: ctl=%b expected=0001", ctl);
        end
        step();
        clearInputs();
        #1;
        checks++;
        if (ctl !== 4'b1100 || CtrlState !== 2'd0 || StallCount !== 32'd1) begin
            errors++; $display("FAIL loaduse_done: ctl=%b state=%0d stall=%0d expected ctl=1100 state=0 stall=1",
                               ctl, CtrlState, StallCount);
        end
    endtask

    task automatic test_redirect_hazard();
        doReset();
        BranchTaken = 1; HazardReq = 1;
        #1;
        checks++;
        if (ctl !== 4'b1111) begin
            errors++; $display("FAIL branch_vs_hazard: ctl=%b expected=1111", ctl);
        end
        step();
        clearInputs();
        #1;
        checks++;
        if (ctl !== 4'b1100 || CtrlState !== 2'd0 || FlushCount !== 32'd1 || StallCount !== 32'd0) begin
            errors++; $display("FAIL branch_after: ctl=%b state=%0d flush=%0d stall=%0d expected 1100/0/1/0",
                               ctl, CtrlState, FlushCount, StallCount);
        end
        JumpTaken = 1;
        #1;
        checks++;
        if (ctl !== 4'b1111) begin
            errors++; $display("FAIL jump_outputs: ctl=%b expected=1111", ctl);
        end
        step();
        clearInputs();
        #1;
        checks++;
        if (FlushCount !== 32'd2) begin
            errors++; $display("FAIL jump_count: flush=%0d expected=2", FlushCount);
        end
    endtask

    task automatic test_ext_stall();
        doReset();
        HazardReq = 1;
        step();
        HazardReq = 0;
        ExtStall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== 4'b0000 || CtrlState !== 2'd1 || StallCount !== 32'd1) begin
                errors++; $display("FAIL ext_freeze%0d: ctl=%b state=%0d stall=%0d expected 0000/1/1",
                                   i, ctl, CtrlState, StallCount);
            end
            step();
        end
        // Freeze beats a concurrent redirect too.
        BranchTaken = 1;
        #1;
        checks++;
        if (ctl !== 4'b0000) begin
            errors++; $display("FAIL ext_over_branch: ctl=%b expected=0000", ctl);
        end
        BranchTaken = 0;
        ExtStall = 0;
        #1;
        checks++;
        if (ctl !== 4'b0001 || CtrlState !== 2'd1) begin
            errors++; $display("FAIL ext_resume: ctl=%b state=%0d expected ctl=0001 state=1", ctl, CtrlState);
        end
        step();
        checks++;
        if (ctl !== 4'b1100 || CtrlState !== 2'd0 || StallCount !== 32'd2 || FlushCount !== 32'd0) begin
            errors++; $display("FAIL ext_done: ctl=%b state=%0d stall=%0d flush=%0d expected 1100/0/2/0",
                               ctl, CtrlState, StallCount, FlushCount);
        end
    endtask

    task automatic test_stall_redirect();
        doReset();
        HazardReq = 1;
        step();
        HazardReq = 0;
        BranchTaken = 1;
        #1;
        checks++;
        if (ctl !== 4'b1111) begin
            errors++; $display("FAIL stall_abort_out: ctl=%b expected=1111", ctl);
        end
        step();
        clearInputs();
        #1;
        checks++;
        if (ctl !== 4'b1100 || CtrlState !== 2'd0 || StallCount !== 32'd1 || FlushCount !== 32'd1) begin
            errors++; $display("FAIL stall_abort_after: ctl=%b state=%0d stall=%0d flush=%0d expected 1100/0/1/1",
                               ctl, CtrlState, StallCount, FlushCount);
        end
    endtask

    task automatic test_reset_mid_stall();
        doReset();
        HazardReq = 1;
        step();
        HazardReq = 0;
        Reset = 1;
        #1;
        checks++;
        if (ctl !== 4'b0011) begin
            errors++; $display("FAIL midreset_out: ctl=%b expected=0011", ctl);
        end
        step();
        Reset = 0;
        #1;
        checks++;
        if (ctl !== 4'b1100 || CtrlState !== 2'd0 || StallCount !== 32'd0) begin
            errors++; $display("FAIL midreset_after: ctl=%b state=%0d stall=%0d expected 1100/0/0",
                               ctl, CtrlState, StallCount);
        end
    endtask

    task automatic test_saturation();
        doReset();
        for (int i = 0; i < 20; i++) begin
            HazardReq = 1;
            step();
            HazardReq = 0;
            step();
        end
        for (int i = 0; i < 20; i++) begin
            BranchTaken = 1;
            step();
        end
        BranchTaken = 0;
        #1;
        checks++;
        if (StallCount !== 32'd40 || FlushCount !== 32'd20) begin
            errors++; $display("FAIL wide_counts: stall=%0d flush=%0d expected 40/20", StallCount, FlushCount);
        end
        checks++;
        if (sStallCount !== 4'd15 || sFlushCount !== 4'd15) begin
            errors++; $display("FAIL sat_counts: stall=%0d flush=%0d expected 15/15", sStallCount, sFlushCount);
        end
        checks++;
        if (sCtrlState !== 2'd0 || {sPCWrite, sIfIdWrite, sIfIdFlush, sIdExBubble} !== 4'b1100) begin
            errors++; $display("FAIL sat_idle: state=%0d ctl=%b expected 0/1100",
                               sCtrlState, {sPCWrite, sIfIdWrite, sIfIdFlush, sIdExBubble});
        end
        doReset();
        checks++;
        if (sStallCount !== 4'd0 || sFlushCount !== 4'd0 || StallCount !== 32'd0) begin
            errors++; $display("FAIL sat_reset: sstall=%0d sflush=%0d stall=%0d expected 0/0/0",
                               sStallCount, sFlushCount, StallCount);
        end
    endtask

    initial begin
        Reset = 1;
        clearInputs();
        test_reset();
        test_raw_stall();
        test_load_use();
        test_redirect_hazard();
        test_ext_stall();
        test_stall_redirect();
        test_reset_mid_stall();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
